// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   pll_sup_state_e : supervisor state (HOLD, WAIT_LOCK, LOCKED)
//   RELOCK_W        : width of the relock statistics counter
//   cnt_width()     : counter width for a modulus, never below 1 bit
package pll_sup_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2
  } pll_sup_state_e;

  localparam int RELOCK_W = 8;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Generic N-flop single-bit synchronizer.
// Ports:
//   clock : destination clock
//   reset : synchronous active-high reset, clears every stage
//   d     : asynchronous input bit
//   q     : synchronized output, STAGES cycles of latency
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p <= '0;
    end else begin
      sync_p[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor, running on the free-running oscillator clock.
// Holds the PLL in reset, waits for a stable synchronized lock, retries the
// PLL on lock timeout, and re-initialises it when lock is lost.
// Ports:
//   clock        : oscillator clock
//   reset        : synchronous active-high reset
//   pll_lock     : PLL LOCK, asynchronous to clock
//   pll_resetb   : PLL reset, active low (registered)
//   locked       : lock confirmed stable (registered)
//   fail         : sticky, MAX_RETRY consecutive timeouts seen
//   relock_count : saturating count of LOCKED->HOLD transitions
// Build option: define PLL_SUPERVISOR_STATS_EN to implement relock_count;
// otherwise the port is tied to zero.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int HOLD_LEN     = 16,
  parameter int STABLE_LEN   = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pll_lock,
  output logic                pll_resetb,
  output logic                locked,
  output logic                fail,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int HOLD_W  = cnt_width(HOLD_LEN);
  localparam int STAB_W  = cnt_width(STABLE_LEN);
  localparam int TMO_W   = cnt_width(LOCK_TIMEOUT);
  // Retry count must be able to hold MAX_RETRY itself.
  localparam int RETRY_W = cnt_width(MAX_RETRY + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_LEN - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST   = STAB_W'(STABLE_LEN - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ALERT = RETRY_W'(MAX_RETRY - 1);

  pll_sup_state_e      state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STAB_W-1:0]   stab_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [RETRY_W-1:0]  retry_cnt;
  logic                lock_s;

  // Synchronizer stage: pll_lock -> lock_s, two cycles of latency
  cdc_sync #(
    .STAGES (2)
  ) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // State stage: pll_resetb and locked are registered decodes of the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      stab_cnt   <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      pll_resetb <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= WAIT_LOCK;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
            stab_cnt   <= '0;
            pll_resetb <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          tmo_cnt  <= tmo_cnt + 1'b1;
          stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
          // Stable lock takes priority over a coincident timeout.
          if (lock_s && (stab_cnt == STAB_LAST)) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            retry_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            pll_resetb <= 1'b0;
            if (retry_cnt != RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
            end
            // This timeout brings (or keeps) the count at MAX_RETRY.
            if (retry_cnt >= RETRY_ALERT) begin
              fail <= 1'b1;
            end
          end
        end

        LOCKED: begin
          if (!lock_s) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            locked     <= 1'b0;
            pll_resetb <= 1'b0;
          end
        end

        default: begin
          state      <= HOLD;
          hold_cnt   <= '0;
          locked     <= 1'b0;
          pll_resetb <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SUPERVISOR_STATS_EN
  logic [RELOCK_W-1:0] relock_q;

  // Statistics stage: counts lock losses, sticks at all-ones
  always_ff @(posedge clock) begin
    if (reset) begin
      relock_q <= '0;
    end else if ((state == LOCKED) && !lock_s && (relock_q != '1)) begin
      relock_q <= relock_q + 1'b1;
    end
  end

  assign relock_count = relock_q;
`else
  assign relock_count = '0;
`endif

endmodule
